fetch_pc_predict: RTL and testbench

- IF-stage next-PC generator that directly consumes the 2-bit predictor's `take` output.
- Holds the PC register and a direct-mapped branch target buffer (BTB).
- Carries each fetched instruction's prediction alongside it into ID, checks it against the resolved outcome there, and issues flush/redirect on a mispredict.
- Drives the predictor's `Branch`/`taken` training inputs.

---
 rtl/fetch_pc_predict_pkg.sv | 17 +
 rtl/fetch_pc_predict_if.sv | 27 ++
 rtl/fetch_pc_predict_btb_array.sv | 52 +++++
 rtl/fetch_pc_predict.sv | 101 ++++++++++
 tb/tb_fetch_pc_predict.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pc_predict_pkg.sv
// Shared fetch-stage constants and the next-PC source encoding.
package fetch_pc_predict_pkg;

    localparam int unsigned PC_W     = 32;
    localparam int unsigned PC_INC   = 4;
    localparam int unsigned RESET_PC = 0;
    // Fetch is word aligned, so the two low PC bits never take part in BTB indexing.
    localparam int unsigned IDX_LSB  = 2;

    typedef enum logic [1:0] {
        NPC_REDIRECT,
        NPC_HOLD,
        NPC_PREDICT,
        NPC_SEQ
    } npc_sel_e;

endpackage

// File: rtl/fetch_pc_predict_if.sv
// IF/ID-side signals of the next-PC generator; master is the fetch unit.
interface fetch_pc_predict_if #(
    parameter int unsigned PC_W = fetch_pc_predict_pkg::PC_W
);

    logic            stall;
    logic            take;
    logic [PC_W-1:0] pc;
    logic            id_branch;
    logic            id_taken;
    logic [PC_W-1:0] id_target;
    logic [PC_W-1:0] id_pc;
    logic            flush;
    logic            bp_update;
    logic            bp_taken;

    modport master (
        input  stall, take, id_branch, id_taken, id_target, id_pc,
        output pc, flush, bp_update, bp_taken
    );

    modport slave (
        output stall, take, id_branch, id_taken, id_target, id_pc,
        input  pc, flush, bp_update, bp_taken
    );

endinterface

// File: rtl/fetch_pc_predict_btb_array.sv
// Direct-mapped BTB storage: async-cleared valid bits, combinational read, synchronous write.
module btb_array #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = PC_W - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [PC_W-1:0]  rd_target_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [PC_W-1:0]  wr_target_i
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];

    always_comb begin
        valid_d = valid_q;
        if (we_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag/target need no reset: they are only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]    <= wr_tag_i;
            target_q[wr_idx_i] <= wr_target_i;
        end
    end

    assign rd_valid_o  = valid_q[rd_idx_i];
    assign rd_tag_o    = tag_q[rd_idx_i];
    assign rd_target_o = target_q[rd_idx_i];

endmodule

// File: rtl/fetch_pc_predict.sv
// IF-stage next-PC generator: PC register, BTB lookup, ID-side prediction check and redirect.
module fetch_pc_predict #(
    parameter  int unsigned PC_W  = fetch_pc_predict_pkg::PC_W,
    parameter  int unsigned IDX_W = 4,
    localparam int unsigned TAG_W = PC_W - IDX_W - 2
) (
    input  logic               clk,
    input  logic               rst,
    fetch_pc_predict_if.master bus
);

    import fetch_pc_predict_pkg::*;

    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;

    logic [PC_W-1:0]  pc_q, pc_d;
    logic             id_pred_taken_q, id_pred_taken_d;
    logic [PC_W-1:0]  id_pred_target_q, id_pred_target_d;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [PC_W-1:0]  rd_target;
    logic             if_pred_taken;
    logic [PC_W-1:0]  if_pred_target;
    logic             mispredict;
    npc_sel_e         npc_sel;

    btb_array #(
        .PC_W  (PC_W),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .rd_idx_i    (pc_q[TAG_LSB-1:IDX_LSB]),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_target_o (rd_target),
        .we_i        (bus.id_branch && bus.id_taken),
        .wr_idx_i    (bus.id_pc[TAG_LSB-1:IDX_LSB]),
        .wr_tag_i    (bus.id_pc[PC_W-1:TAG_LSB]),
        .wr_target_i (bus.id_target)
    );

    always_comb begin
        if_pred_taken  = rd_valid && (rd_tag == pc_q[PC_W-1:TAG_LSB]) && bus.take;
        if_pred_target = rd_target;
        mispredict     = bus.id_branch &&
                         ((bus.id_taken != id_pred_taken_q) ||
                          (bus.id_taken && (bus.id_target != id_pred_target_q)));
    end

    // A mispredict outranks stall so the redirect and ID bubble are never lost.
    always_comb begin
        npc_sel          = NPC_SEQ;
        pc_d             = pc_q + PC_W'(PC_INC);
        id_pred_taken_d  = if_pred_taken;
        id_pred_target_d = if_pred_target;

        if (mispredict) begin
            npc_sel = NPC_REDIRECT;
        end else if (bus.stall) begin
            npc_sel = NPC_HOLD;
        end else if (if_pred_taken) begin
            npc_sel = NPC_PREDICT;
        end

        unique case (npc_sel)
            NPC_REDIRECT: begin
                pc_d             = bus.id_taken ? bus.id_target : bus.id_pc + PC_W'(PC_INC);
                id_pred_taken_d  = 1'b0;
                id_pred_target_d = '0;
            end
            NPC_HOLD: begin
                pc_d             = pc_q;
                id_pred_taken_d  = id_pred_taken_q;
                id_pred_target_d = id_pred_target_q;
            end
            NPC_PREDICT: pc_d = if_pred_target;
            NPC_SEQ: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q             <= PC_W'(RESET_PC);
            id_pred_taken_q  <= 1'b0;
            id_pred_target_q <= '0;
        end else begin
            pc_q             <= pc_d;
            id_pred_taken_q  <= id_pred_taken_d;
            id_pred_target_q <= id_pred_target_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.flush     = mispredict;
    assign bus.bp_update = bus.id_branch;
    assign bus.bp_taken  = bus.id_taken;

endmodule

// File: tb/tb_fetch_pc_predict.sv
// Directed bench for fetch_pc_predict: sequential fetch, BTB fill/hit, mispredicts, stall, aliasing, reset, wrap.
module tb_fetch_pc_predict;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    fetch_pc_predict_if #(.PC_W(32)) bus ();

    fetch_pc_predict #(.PC_W(32), .IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic br(input logic taken, input logic [31:0] tgt, input logic [31:0] ipc);
        bus.id_branch = 1'b1;
        bus.id_taken  = taken;
        bus.id_target = tgt;
        bus.id_pc     = ipc;
    endtask

    task automatic nobr();
        bus.id_branch = 1'b0;
        bus.id_taken  = 1'b0;
        bus.id_target = '0;
        bus.id_pc     = '0;
    endtask

    initial begin
        rst       = 1'b0;
        bus.stall = 1'b0;
        bus.take  = 1'b0;
        nobr();
        #12;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_bpu", 32'(bus.bp_update), 32'd0);
        chk("rst_pred", 32'(dut.id_pred_taken_q), 32'd0);
        rst = 1'b1;

        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("seq_pc", bus.pc, 32'(4 * i));
            chk("seq_bpu", 32'(bus.bp_update), 32'd0);
        end

        // cold taken branch at 0x10
        br(1'b1, 32'h80, 32'h10);
        #1;
        chk("cold_flush", 32'(bus.flush), 32'd1);
        chk("cold_bpu", 32'(bus.bp_update), 32'd1);
        chk("cold_bpt", 32'(bus.bp_taken), 32'd1);
        tick();
        chk("cold_pc", bus.pc, 32'h80);

        // revisit 0x10 with take=1
        br(1'b1, 32'h10, 32'h84);
        #1;
        chk("redir_flush", 32'(bus.flush), 32'd1);
        tick();
        chk("redir_pc", bus.pc, 32'h10);
        nobr();
        bus.take = 1'b1;
        tick();
        chk("hit_pc", bus.pc, 32'h80);
        chk("hit_pred", 32'(dut.id_pred_taken_q), 32'd1);
        br(1'b1, 32'h80, 32'h10);
        #1;
        chk("ok_flush", 32'(bus.flush), 32'd0);
        chk("ok_bpu", 32'(bus.bp_update), 32'd1);
        tick();
        chk("ok_pc", bus.pc, 32'h84);

        // revisit with take=0
        bus.take = 1'b0;
        br(1'b1, 32'h10, 32'h84);
        #1;
        chk("redir2_flush", 32'(bus.flush), 32'd1);
        tick();
        chk("redir2_pc", bus.pc, 32'h10);
        nobr();
        tick();
        chk("notake_pc", bus.pc, 32'h14);

        // predicted taken, resolves not taken
        br(1'b1, 32'h10, 32'h84);
        tick();
        chk("redir3_pc", bus.pc, 32'h10);
        nobr();
        bus.take = 1'b1;
        tick();
        chk("pt_pc", bus.pc, 32'h80);
        chk("pt_pred", 32'(dut.id_pred_taken_q), 32'd1);
        bus.take = 1'b0;
        br(1'b0, 32'h0, 32'h10);
        #1;
        chk("mp_flush", 32'(bus.flush), 32'd1);
        chk("mp_bpt", 32'(bus.bp_taken), 32'd0);
        tick();
        chk("mp_pc", bus.pc, 32'h14);
        chk("mp_pred", 32'(dut.id_pred_taken_q), 32'd0);
        br(1'b1, 32'h10, 32'h84);
        tick();
        chk("redir4_pc", bus.pc, 32'h10);
        nobr();
        bus.take = 1'b1;
        tick();
        chk("still_hit_pc", bus.pc, 32'h80);

        // build a prediction into 0x20, then stall on it
        bus.take = 1'b0;
        br(1'b1, 32'h20, 32'h1C);
        #1;
        chk("tgt_mp_flush", 32'(bus.flush), 32'd1);
        tick();
        chk("to20_pc", bus.pc, 32'h20);
        br(1'b1, 32'h1C, 32'h84);
        tick();
        chk("to1c_pc", bus.pc, 32'h1C);
        nobr();
        bus.take = 1'b1;
        tick();
        chk("hit1c_pc", bus.pc, 32'h20);
        chk("hit1c_ptgt", dut.id_pred_target_q, 32'h20);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", bus.pc, 32'h20);
            chk("stall_pred", 32'(dut.id_pred_taken_q), 32'd1);
            chk("stall_ptgt", dut.id_pred_target_q, 32'h20);
        end
        br(1'b1, 32'h40, 32'h20);
        #1;
        chk("stmp_flush", 32'(bus.flush), 32'd1);
        tick();
        chk("stmp_pc", bus.pc, 32'h40);
        chk("stmp_pred", 32'(dut.id_pred_taken_q), 32'd0);
        bus.stall = 1'b0;
        nobr();
        bus.take = 1'b0;

        // aliasing: 0x50 shares index 4 with 0x10 but has a different tag
        br(1'b1, 32'h50, 32'h84);
        tick();
        chk("to50_pc", bus.pc, 32'h50);
        nobr();
        bus.take = 1'b1;
        tick();
        chk("alias_pc", bus.pc, 32'h54);

        // asynchronous reset mid-run invalidates the BTB
        #2;
        rst = 1'b0;
        #1;
        chk("mr_pc", bus.pc, 32'h0);
        chk("mr_pred", 32'(dut.id_pred_taken_q), 32'd0);
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("mr_seq_pc", bus.pc, 32'(4 * i));
        end
        tick();
        chk("mr_miss_pc", bus.pc, 32'h14);

        // PC wraps modulo 2^32
        bus.take = 1'b0;
        br(1'b1, 32'hFFFF_FFFC, 32'h84);
        tick();
        chk("wrap_top_pc", bus.pc, 32'hFFFF_FFFC);
        nobr();
        tick();
        chk("wrap_pc", bus.pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
